// File: rtl/jmp_pkg.sv
// Shared definitions for the jump/branch address unit: jump mode codes.
package jmp_pkg;

  localparam int unsigned JM_W = 3;

  localparam logic [JM_W-1:0] JM_ABS   = 3'b000;
  localparam logic [JM_W-1:0] JM_BASE  = 3'b001;
  localparam logic [JM_W-1:0] JM_PCREL = 3'b010;
  localparam logic [JM_W-1:0] JM_CALL  = 3'b011;
  localparam logic [JM_W-1:0] JM_CALLA = 3'b100;
  localparam logic [JM_W-1:0] JM_RET   = 3'b101;

endpackage

// File: rtl/jmp_ras.sv
// Circular hardware return-address stack; a push while full overwrites the oldest entry.
module jmp_ras #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf_ev,
  output logic             unf_ev
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp, tp_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  // Pointer/count advance; a pop on an empty stack leaves everything alone.
  always_comb begin
    tp_nxt  = tp;
    cnt_nxt = cnt;
    if (push) begin
      tp_nxt  = tp + PW'(1);
      cnt_nxt = full ? cnt : cnt + CW'(1);
    end else if (pop && !empty) begin
      tp_nxt  = tp - PW'(1);
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      tp    <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push) begin
        mem[tp_nxt] <= push_data;
      end
      tp    <= tp_nxt;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
    end
  end

  assign top    = mem[tp];
  assign ovf_ev = push & full;
  assign unf_ev = pop & empty;

endmodule

// File: rtl/jmp_ctrl.sv
// Jump/branch next-address unit with base register and return stack.
// Optional target bounds checking (bnd_err port) is enabled by defining JMP_BOUNDS_CHK_EN.
module jmp_ctrl
  import jmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RAS_DEPTH = 4
`ifdef JMP_BOUNDS_CHK_EN
  , parameter int unsigned ADDR_LIMIT = (2**WIDTH) - 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             jmp_en,
  input  logic [JM_W-1:0]  jmp_mode,
  input  logic [WIDTH-1:0] offset,
  input  logic             base_reg_ld,
  input  logic [WIDTH-1:0] base_reg_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_addr,
  output logic             jmp_taken,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
`ifdef JMP_BOUNDS_CHK_EN
  , output logic           bnd_err
`endif
);

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] ras_top;
  logic             sel_take, sel_push, sel_pop;
  logic             take, push, pop;
  logic             ovf_ev, unf_ev;

  assign pc_inc = pc + WIDTH'(1);

  // Mode decode: candidate target plus the stack operation it implies.
  always_comb begin
    tgt      = pc_inc;
    sel_take = 1'b0;
    sel_push = 1'b0;
    sel_pop  = 1'b0;
    if (jmp_en) begin
      case (jmp_mode)
        JM_ABS: begin
          tgt      = offset;
          sel_take = 1'b1;
        end
        JM_BASE: begin
          tgt      = base_q + offset;
          sel_take = 1'b1;
        end
        JM_PCREL: begin
          tgt      = pc + offset;
          sel_take = 1'b1;
        end
        JM_CALL: begin
          tgt      = base_q + offset;
          sel_take = 1'b1;
          sel_push = 1'b1;
        end
        JM_CALLA: begin
          tgt      = offset;
          sel_take = 1'b1;
          sel_push = 1'b1;
        end
        JM_RET: begin
          sel_pop = 1'b1;
          if (!ras_empty) begin
            tgt      = ras_top;
            sel_take = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef JMP_BOUNDS_CHK_EN
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(ADDR_LIMIT);
  logic fault;

  // An out-of-range target cancels the whole operation, stack included.
  assign fault = sel_take && (tgt > LIMIT);
  assign take  = sel_take & ~fault;
  assign push  = sel_push & ~fault;
  assign pop   = sel_pop  & ~fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd_err <= 1'b0;
    end else begin
      bnd_err <= fault | (bnd_err & ~err_clr);
    end
  end
`else
  assign take = sel_take;
  assign push = sel_push;
  assign pop  = sel_pop;
`endif

  assign out_addr  = take ? tgt : pc_inc;
  assign jmp_taken = take;

  jmp_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf_ev    (ovf_ev),
    .unf_ev    (unf_ev)
  );

  // Base register and sticky stack errors; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (base_reg_ld) begin
        base_q <= base_reg_data;
      end
      ras_ovf <= ovf_ev | (ras_ovf & ~err_clr);
      ras_unf <= unf_ev | (ras_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_jmp_ctrl.sv
// Self-checking bench for jmp_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_jmp_ctrl;
  import jmp_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef JMP_BOUNDS_CHK_EN
  localparam int unsigned LIMIT = 'h7F;
`else
  localparam int unsigned LIMIT = 'hFF;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    pc;
  logic            jmp_en;
  logic [JM_W-1:0] jmp_mode;
  logic [W-1:0]    offset;
  logic            base_reg_ld;
  logic [W-1:0]    base_reg_data;
  logic            err_clr;
  logic [W-1:0]    out_addr;
  logic            jmp_taken;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;
  logic            ras_unf;
`ifdef JMP_BOUNDS_CHK_EN
  logic            bnd_err;
`endif

  always #5 clk = ~clk;

  jmp_ctrl #(
    .WIDTH      (W),
    .RAS_DEPTH  (D)
`ifdef JMP_BOUNDS_CHK_EN
    , .ADDR_LIMIT (LIMIT)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .jmp_en        (jmp_en),
    .jmp_mode      (jmp_mode),
    .offset        (offset),
    .base_reg_ld   (base_reg_ld),
    .base_reg_data (base_reg_data),
    .err_clr       (err_clr),
    .out_addr      (out_addr),
    .jmp_taken     (jmp_taken),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf)
`ifdef JMP_BOUNDS_CHK_EN
    , .bnd_err     (bnd_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: stack as a queue (back = most recent), base, sticky flags.
  logic [W-1:0] m_ras [$];
  logic [W-1:0] m_base;
  logic         m_ovf, m_unf;
`ifdef JMP_BOUNDS_CHK_EN
  logic         m_bnd;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ras.delete();
    m_base = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
`ifdef JMP_BOUNDS_CHK_EN
    m_bnd  = 1'b0;
`endif
  endtask

  function automatic logic [W-1:0] bnd(input logic [W-1:0] t, input logic [W-1:0] p);
    return (int'(t) > int'(LIMIT)) ? p + W'(1) : t;
  endfunction

  // One clock: drive, check combinational and flag outputs, then advance the model at the edge.
  task automatic cyc(input bit en, input logic [2:0] md, input logic [W-1:0] off,
                     input bit ld, input logic [W-1:0] ldd, input bit clr,
                     input logic [W-1:0] p, input int want);
    logic [W-1:0] pc1, tgt;
    bit take, push, pop, fault;
    jmp_en = en; jmp_mode = md; offset = off; base_reg_ld = ld;
    base_reg_data = ldd; err_clr = clr; pc = p;
    #1;
    pc1 = p + W'(1);
    tgt = pc1; take = 0; push = 0; pop = 0;
    if (en) begin
      case (md)
        JM_ABS:   begin tgt = off;          take = 1; end
        JM_BASE:  begin tgt = m_base + off; take = 1; end
        JM_PCREL: begin tgt = p + off;      take = 1; end
        JM_CALL:  begin tgt = m_base + off; take = 1; push = 1; end
        JM_CALLA: begin tgt = off;          take = 1; push = 1; end
        JM_RET: begin
          pop = 1;
          if (m_ras.size() > 0) begin
            tgt  = m_ras[m_ras.size()-1];
            take = 1;
          end
        end
        default: begin end
      endcase
    end
    fault = take && (int'(tgt) > int'(LIMIT));
    if (fault) begin
      take = 0; push = 0; pop = 0; tgt = pc1;
    end
    check("out_addr",  32'(out_addr),  32'(take ? tgt : pc1));
    check("jmp_taken", 32'(jmp_taken), 32'(take));
    check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    check("ras_full",  32'(ras_full),  32'(m_ras.size() == D));
    check("ras_ovf",   32'(ras_ovf),   32'(m_ovf));
    check("ras_unf",   32'(ras_unf),   32'(m_unf));
`ifdef JMP_BOUNDS_CHK_EN
    check("bnd_err",   32'(bnd_err),   32'(m_bnd));
`endif
    if (want >= 0) check("plan_addr", 32'(out_addr), 32'(want));
    @(posedge clk);
    if (clr) begin
      m_ovf = 0; m_unf = 0;
`ifdef JMP_BOUNDS_CHK_EN
      m_bnd = 0;
`endif
    end
`ifdef JMP_BOUNDS_CHK_EN
    if (fault) m_bnd = 1;
`endif
    if (push) begin
      if (m_ras.size() == D) begin
        m_ovf = 1;
        void'(m_ras.pop_front());
      end
      m_ras.push_back(pc1);
    end
    if (pop) begin
      if (m_ras.size() == 0) m_unf = 1;
      else void'(m_ras.pop_back());
    end
    if (ld) m_base = ldd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc = 8'h10; jmp_en = 1'b0; jmp_mode = '0; offset = '0;
    base_reg_ld = 1'b0; base_reg_data = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check("rst_out_addr", 32'(out_addr),  32'h11);
    check("rst_taken",    32'(jmp_taken), 32'h0);
    check("rst_empty",    32'(ras_empty), 32'h1);
    check("rst_full",     32'(ras_full),  32'h0);
    check("rst_ovf",      32'(ras_ovf),   32'h0);
    check("rst_unf",      32'(ras_unf),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(0, JM_ABS, 8'h00, 0, 8'h00, 0, 8'h10, 'h11);
    // Base load is not bypassed to a same-cycle BASE jump.
    cyc(1, JM_BASE, 8'h05, 1, 8'h40, 0, 8'h00, int'(bnd(8'h05, 8'h00)));
    cyc(1, JM_BASE, 8'h05, 0, 8'h00, 0, 8'h06, int'(bnd(8'h45, 8'h06)));
    cyc(1, JM_PCREL, 8'hFC, 0, 8'h00, 0, 8'h02, int'(bnd(8'hFE, 8'h02)));
    cyc(1, JM_ABS, 8'h00, 0, 8'h00, 0, 8'hFE, 'h00);

    cyc(1, JM_CALLA, 8'h30, 0, 8'h00, 0, 8'h10, 'h30);
    cyc(1, JM_CALLA, 8'h50, 0, 8'h00, 0, 8'h31, 'h50);
    cyc(1, JM_RET,   8'h00, 0, 8'h00, 0, 8'h50, 'h32);
    cyc(1, JM_RET,   8'h00, 0, 8'h00, 0, 8'h33, 'h11);
    check("plan_empty_after_ret", 32'(ras_empty), 32'h1);
    check("plan_no_flags", 32'({ras_ovf, ras_unf}), 32'h0);

    for (int i = 1; i <= 5; i++) begin
      cyc(1, JM_CALLA, 8'h10, 0, 8'h00, 0, W'(i), 'h10);
    end
    check("plan_full", 32'(ras_full), 32'h1);
    check("plan_ovf",  32'(ras_ovf),  32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, JM_RET, 8'h00, 0, 8'h00, 0, 8'h10, 6 - i);
    end
    cyc(1, JM_RET, 8'h00, 0, 8'h00, 0, 8'h10, 'h11);
    check("plan_unf", 32'(ras_unf), 32'h1);
    cyc(0, JM_ABS, 8'h00, 0, 8'h00, 1, 8'h20, 'h21);
    check("plan_clr", 32'({ras_ovf, ras_unf}), 32'h0);

    cyc(1, JM_CALLA, 8'h90, 0, 8'h00, 0, 8'h20, int'(bnd(8'h90, 8'h20)));
    cyc(0, JM_ABS, 8'h00, 0, 8'h00, 0, 8'h21, 'h22);

    // Asynchronous reset in the middle of a call sequence empties the stack at once.
    cyc(1, JM_CALLA, 8'h10, 0, 8'h00, 0, 8'h01, -1);
    cyc(1, JM_CALLA, 8'h10, 0, 8'h00, 0, 8'h02, -1);
    jmp_en = 1'b0; pc = 8'h40;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_empty", 32'(ras_empty), 32'h1);
    check("midrst_full",  32'(ras_full),  32'h0);
    check("midrst_addr",  32'(out_addr),  32'h41);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, JM_RET, 8'h00, 0, 8'h00, 0, 8'h40, 'h41);

    repeat (400) begin
      cyc(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
          ($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 7) == 0),
          8'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
